// File: rtl/pwm_cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cap_pkg
//  Brief    : Shared widths, limits, FSM state type and saturating increments
//             for the PWM capture block.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_cap_pkg;

    localparam int DUTY_W = 11;
    localparam int PER_W  = 12;

    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;
    localparam logic [PER_W-1:0]  PER_MAX  = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    function automatic logic [DUTY_W-1:0] inc_sat_duty(input logic [DUTY_W-1:0] v);
        return (v == DUTY_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [PER_W-1:0] inc_sat_per(input logic [PER_W-1:0] v);
        return (v == PER_MAX) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Brief    : Multi-flop synchronizer plus history flop producing the
//             synchronized level and single-cycle rise/fall strobes.
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Brief    : Measures high time and rise-to-rise period of an asynchronous
//             PWM input, flagging a stuck signal after a timeout.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PWM_in,
    output logic [DUTY_W-1:0] duty,
    output logic [PER_W-1:0]  period,
    output logic              vld,
    output logic              err
);

    localparam logic [PER_W-1:0] TIMEOUT_CNT = PER_W'(TIMEOUT);

    logic sync_lvl, rise, fall, timeout;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] hi_q, hi_d, duty_q, duty_d;
    logic [PER_W-1:0]  per_q, per_d, period_q, period_d;
    logic              vld_q, vld_d, err_q, err_d;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (PWM_in),
        .sync_o  (sync_lvl),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A rise always beats a coincident timeout.
    assign timeout = (per_q >= TIMEOUT_CNT) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = HIGH;
        end else if (timeout) begin
            state_d = IDLE;
        end else if ((state_q == HIGH) && fall) begin
            state_d = LOW;
        end
    end

    always_comb begin
        hi_d     = hi_q;
        per_d    = inc_sat_per(per_q);
        duty_d   = duty_q;
        period_d = period_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        if (rise) begin
            hi_d  = DUTY_W'(1);
            per_d = PER_W'(1);
            // Only a rise that closes a started period yields a measurement.
            if (state_q == LOW) begin
                duty_d   = hi_q;
                period_d = per_q;
                vld_d    = 1'b1;
                err_d    = 1'b0;
            end
        end else if (timeout) begin
            hi_d     = '0;
            per_d    = '0;
            duty_d   = sync_lvl ? DUTY_MAX : '0;
            period_d = '0;
            err_d    = 1'b1;
        end else if ((state_q == HIGH) && !fall) begin
            hi_d = inc_sat_duty(hi_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            per_q    <= '0;
            duty_q   <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign vld    = vld_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Brief    : Self-checking bench for pwm_capture using an edge-timestamp
//             reference model and scenario-specific constant checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

    localparam int          S  = 2;
    localparam int unsigned TO = 4095;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        PWM_in = 1'b0;
    logic [10:0] duty;
    logic [11:0] period;
    logic        vld;
    logic        err;

    int checks = 0;
    int errors = 0;

    pwm_capture #(
        .SYNC_STAGES (S),
        .TIMEOUT     (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .PWM_in (PWM_in),
        .duty   (duty),
        .period (period),
        .vld    (vld),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Reference model: tracks edge indices of synchronized rises/falls and
    // derives measurements as timestamp differences.
    logic [S:0]  m_sh;
    int unsigned m_k, m_rise_t, m_fall_t, m_idle_t, m_now, m_deadline;
    logic        m_started, m_fell, m_rise, m_fall;
    logic        e_vld, e_err;
    logic [10:0] e_duty;
    logic [11:0] e_period;

    assign m_rise     = m_sh[S-1] & ~m_sh[S];
    assign m_fall     = ~m_sh[S-1] & m_sh[S];
    assign m_now      = m_k + 1;
    assign m_deadline = m_started ? (m_rise_t + TO) : (m_idle_t + TO + 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh      <= '0;
            m_k       <= 0;
            m_rise_t  <= 0;
            m_fall_t  <= 0;
            m_idle_t  <= 0;
            m_started <= 1'b0;
            m_fell    <= 1'b0;
            e_vld     <= 1'b0;
            e_err     <= 1'b0;
            e_duty    <= '0;
            e_period  <= '0;
        end else begin
            m_sh  <= {m_sh[S-1:0], PWM_in};
            m_k   <= m_now;
            e_vld <= 1'b0;
            if (m_rise) begin
                if (m_started) begin
                    e_vld    <= 1'b1;
                    e_err    <= 1'b0;
                    e_duty   <= (m_fall_t - m_rise_t > 2047) ? 11'h7FF : 11'(m_fall_t - m_rise_t);
                    e_period <= (m_now - m_rise_t > 4095) ? 12'hFFF : 12'(m_now - m_rise_t);
                end
                m_started <= 1'b1;
                m_fell    <= 1'b0;
                m_rise_t  <= m_now;
            end else if (m_now >= m_deadline) begin
                e_err     <= 1'b1;
                e_duty    <= m_sh[S-1] ? 11'h7FF : 11'h000;
                e_period  <= '0;
                m_started <= 1'b0;
                m_idle_t  <= m_now;
            end else if (m_fall && m_started && !m_fell) begin
                m_fell   <= 1'b1;
                m_fall_t <= m_now;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        PWM_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        PWM_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (duty !== 11'd0)   begin errors++; $display("FAIL reset_duty got=%0d want=0", duty); end
        checks++; if (period !== 12'd0) begin errors++; $display("FAIL reset_period got=%0d want=0", period); end
        checks++; if (vld !== 1'b0)     begin errors++; $display("FAIL reset_vld got=%b want=0", vld); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pwm11();
        int          nvld = 0;
        logic [10:0] ld   = '0;
        logic [11:0] lp   = '0;
        logic        le   = 1'b1;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 2048; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL pwm11 t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin nvld++; ld = duty; lp = period; le = err; end
                PWM_in = (c < 512);
            end
        end
        checks++; if (nvld != 2) begin errors++; $display("FAIL pwm11_count got=%0d want=2", nvld); end
        checks++;
        if (ld !== 11'd512 || lp !== 12'd2048 || le !== 1'b0) begin
            errors++;
            $display("FAIL pwm11_meas got duty=%0d period=%0d err=%b want 512/2048/0", ld, lp, le);
        end
    endtask

    task automatic test_duty_change();
        int          nvld = 0;
        logic [10:0] ld   = '0;
        logic [10:0] chg  = '0;
        logic [11:0] lp   = '0;
        int          d;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 2048; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL duty_change t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin
                    nvld++; ld = duty; lp = period;
                    if (p == 2) chg = duty;
                end
                d = (p >= 2 || (p == 1 && c >= 1800)) ? 100 : 1500;
                PWM_in = (c < d);
            end
        end
        checks++; if (chg !== 11'd1500) begin errors++; $display("FAIL duty_change_mid got=%0d want=1500", chg); end
        checks++;
        if (nvld != 3 || ld !== 11'd100 || lp !== 12'd2048) begin
            errors++;
            $display("FAIL duty_change_after got n=%0d duty=%0d period=%0d want 3/100/2048", nvld, ld, lp);
        end
    endtask

    task automatic test_timeout();
        int          nvld  = 0;
        int          nlate = 0;
        logic [10:0] ld    = '0;
        logic [11:0] lp    = '0;
        logic        le    = 1'b1;
        apply_reset();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            checks++;
            if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                errors++;
                $display("FAIL timeout_low t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                         $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
            end
            if (vld) nvld++;
            PWM_in = 1'b0;
        end
        checks++;
        if (err !== 1'b1 || duty !== 11'd0 || period !== 12'd0 || nvld != 0) begin
            errors++;
            $display("FAIL timeout_low_flag got err=%b duty=%0d period=%0d n=%0d want 1/0/0/0", err, duty, period, nvld);
        end
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL timeout_recover t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin nvld++; ld = duty; lp = period; le = err; end
                PWM_in = (c < 300);
            end
        end
        checks++;
        if (nvld != 2 || ld !== 11'd300 || lp !== 12'd1000 || le !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover_meas got n=%0d duty=%0d period=%0d err=%b want 2/300/1000/0", nvld, ld, lp, le);
        end
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            checks++;
            if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                errors++;
                $display("FAIL timeout_high t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                         $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
            end
            if (vld && c >= 10) nlate++;
            PWM_in = 1'b1;
        end
        checks++;
        if (err !== 1'b1 || duty !== 11'h7FF || period !== 12'd0 || nlate != 0) begin
            errors++;
            $display("FAIL timeout_high_flag got err=%b duty=%0d period=%0d n=%0d want 1/2047/0/0", err, duty, period, nlate);
        end
    endtask

    task automatic test_reset_mid();
        int          nvld = 0;
        logic [10:0] ld   = '0;
        logic [11:0] lp   = '0;
        apply_reset();
        for (int c = 0; c < 2100; c++) begin
            @(negedge clk);
            checks++;
            if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                errors++;
                $display("FAIL reset_mid_pre t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                         $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
            end
            PWM_in = ((c % 1000) < 300);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vld, duty, period, err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_async got vld=%b duty=%0d period=%0d err=%b want all 0", vld, duty, period, err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2900; c++) begin
            @(negedge clk);
            checks++;
            if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                errors++;
                $display("FAIL reset_mid_post t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                         $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
            end
            if (vld) begin nvld++; ld = duty; lp = period; end
            PWM_in = (c < 900) ? (c < 200) : (((c - 900) % 1000) < 300);
        end
        checks++;
        if (nvld != 2 || ld !== 11'd300 || lp !== 12'd1000) begin
            errors++;
            $display("FAIL reset_mid_meas got n=%0d duty=%0d period=%0d want 2/300/1000", nvld, ld, lp);
        end
    endtask

    task automatic test_pulse();
        int nvld = 0;
        apply_reset();
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL pulse t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin
                    nvld++;
                    checks++;
                    if (c != 3 || duty !== 11'd1 || period !== 12'd10) begin
                        errors++;
                        $display("FAIL pulse_meas got slot=%0d duty=%0d period=%0d want 3/1/10", c, duty, period);
                    end
                end
                PWM_in = (c < 1);
            end
        end
        checks++; if (nvld != 9) begin errors++; $display("FAIL pulse_count got=%0d want=9", nvld); end
    endtask

    task automatic test_saturate();
        logic [10:0] ld = '0;
        logic [11:0] lp = '0;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3100; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL sat_duty t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin ld = duty; lp = period; end
                PWM_in = (c < 2500);
            end
        end
        checks++;
        if (ld !== 11'h7FF || lp !== 12'd3100) begin
            errors++;
            $display("FAIL sat_duty_meas got duty=%0d period=%0d want 2047/3100", ld, lp);
        end
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4095; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL rise_wins t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) begin ld = duty; lp = period; end
                PWM_in = (c < 100);
            end
        end
        checks++;
        if (ld !== 11'd100 || lp !== 12'd4095 || err !== 1'b0) begin
            errors++;
            $display("FAIL rise_wins_meas got duty=%0d period=%0d err=%b want 100/4095/0", ld, lp, err);
        end
    endtask

    task automatic test_random();
        int nvld = 0;
        int hi, lo;
        apply_reset();
        for (int p = 0; p < 25; p++) begin
            hi = int'($urandom_range(1, 80));
            lo = int'($urandom_range(1, 80));
            for (int c = 0; c < hi + lo; c++) begin
                @(negedge clk);
                checks++;
                if ({vld, duty, period, err} !== {e_vld, e_duty, e_period, e_err}) begin
                    errors++;
                    $display("FAIL random t=%0t got vld=%b duty=%0d period=%0d err=%b want vld=%b duty=%0d period=%0d err=%b",
                             $time, vld, duty, period, err, e_vld, e_duty, e_period, e_err);
                end
                if (vld) nvld++;
                PWM_in = (c < hi);
            end
        end
        checks++; if (nvld != 24) begin errors++; $display("FAIL random_count got=%0d want=24", nvld); end
    endtask

    initial begin
        test_reset();
        test_pwm11();
        test_duty_change();
        test_timeout();
        test_reset_mid();
        test_pulse();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on PWM_in (minimum 2).
REQ-002 SHALL have parameter TIMEOUT, default 4095, giving the number of clk cycles without a completed period before err is flagged.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PWM_in  input  1  asynchronous PWM waveform to measure.
REQ-006 duty  output  11  high time of the last complete period, in clk cycles.
REQ-007 period  output  12  length of the last complete period (rise to rise), in clk cycles.
REQ-008 vld  output  1  one-cycle pulse when duty and period update with a new measurement.
REQ-009 err  output  1  signal-stuck flag.

Function
REQ-010 PWM_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-011 FSM SHALL have three states: IDLE, HIGH and LOW.
REQ-012 In IDLE, a rise SHALL move the FSM to HIGH and load hi_cnt=1 and per_cnt=1, with no vld.
REQ-013 In HIGH, each cycle SHALL increment hi_cnt and per_cnt; a fall SHALL move the FSM to LOW, and hi_cnt SHALL freeze.
REQ-014 In LOW, each cycle SHALL increment per_cnt.
REQ-015 A rise in LOW SHALL register duty=hi_cnt, period=per_cnt and vld=1 on the same edge, reload hi_cnt=1 and per_cnt=1, and move the FSM to HIGH.
REQ-016 Latency: with SYNC_STAGES=2, vld SHALL be high in the cycle after the 3rd clk edge at which PWM_in samples high (the first such sample counts as edge 1).
REQ-017 vld SHALL be high for exactly one cycle per measurement; duty and period SHALL hold between measurements.
REQ-018 hi_cnt SHALL saturate at 2047 and per_cnt SHALL saturate at 4095; there is no wrap-around.
REQ-019 The first rise after reset or after a timeout SHALL only start a measurement; no partial period is ever reported.
REQ-020 per_cnt SHALL also count in IDLE; the counter is cleared to 0 on entering IDLE.
REQ-021 When per_cnt reaches TIMEOUT without a rise in LOW, the block SHALL:
  - set err=1 and enter IDLE, with no vld;
  - set duty=0 if the synchronized level is low, or duty=11'h7FF if it is high;
  - set period=0.
REQ-022 When a rise and a timeout occur in the same cycle, the rise SHALL win and the timeout SHALL be ignored.
REQ-023 err SHALL stay set until the next vld pulse, and SHALL clear on the same edge that vld asserts.
REQ-024 A single-cycle high pulse seen after synchronization SHALL be measured as duty=1.

Reset
REQ-025 Asserting rst_n low SHALL immediately set duty=0, period=0, vld=0 and err=0, put the FSM in IDLE, and clear all counters, synchronizer flops and the history flop.
REQ-026 Reset asserted mid-period SHALL discard that period; after release, measurement SHALL restart per REQ-019.
REQ-027 A PWM_in held high through reset SHALL be seen as a rise after synchronization; that rise only starts a measurement.

Structure
REQ-028 Package pwm_cap_pkg SHALL hold:
  - DUTY_W=11, PER_W=12, DUTY_MAX=11'h7FF;
  - the FSM state enum typedef (IDLE, HIGH, LOW).
REQ-029 Sub-module sync_edge SHALL hold the SYNC_STAGES synchronizer, the history flop and the rise/fall outputs; pwm_capture holds the FSM, counters and output registers.

Verification
REQ-030 PWM11 generator with duty=512 drives PWM_in -> from the 2nd rise on, each period gives vld with duty=512, period=2048 and err=0.
REQ-031 Generator duty changed from 1500 to 100 mid-period -> that period reports duty=1500 (or the boundary value); every period after it reports duty=100, period=2048.
REQ-032 PWM_in held low from reset release for 5000 cycles -> err=1 after 4095 cycles with duty=0, period=0 and no vld; then a 300-high/700-low waveform -> first vld reports duty=300, period=1000, err=0.
REQ-033 PWM_in held high for 5000 cycles after a valid period -> err=1 with duty=11'h7FF and no vld.
REQ-034 rst_n pulsed low during the HIGH phase -> all outputs 0 asynchronously; no vld until the 2nd rise after release.
REQ-035 One-cycle high pulse every 10 cycles -> each vld reports duty=1, period=10.
